// File: rtl/lsu_pkg.sv
// Shared types and size helpers for the load/store alignment controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RESP
    } lsu_state_t;

    // Encoding 3 on the request bus is treated as a word access.
    function automatic access_size_t decode_size(input logic [1:0] raw);
        return (raw == 2'd3) ? SZ_WORD : access_size_t'(raw);
    endfunction

    function automatic logic [3:0] size_mask(input access_size_t sz);
        case (sz)
            SZ_BYTE: return 4'b0001;
            SZ_HALF: return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input access_size_t sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic needs_split(input logic [1:0] off, input access_size_t sz);
        return ({1'b0, off} + size_bytes(sz)) > 3'd4;
    endfunction

endpackage

// File: rtl/misaligned_access_ctrl_if.sv
// Word-aligned data-memory bus with byte strobes and single-cycle acknowledge.
interface misaligned_access_ctrl_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_strb_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_strb_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_strb_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: strobes and write data for both beats, plus load merge and extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]   i_off,
    input  access_size_t i_size,
    input  logic         i_unsigned,
    input  logic [31:0]  i_wdata,
    input  logic [31:0]  i_lo,
    input  logic [31:0]  i_hi,
    output logic [3:0]   o_strb0,
    output logic [3:0]   o_strb1,
    output logic [31:0]  o_wdata0,
    output logic [31:0]  o_wdata1,
    output logic [31:0]  o_rdata
);

    logic [4:0]  w_shift;
    logic [7:0]  w_strb_wide;
    logic [63:0] w_wdata_wide;
    logic [31:0] w_raw;

    assign w_shift      = {i_off, 3'b000};
    // Upper halves of the widened vectors are exactly what spills into the next word.
    assign w_strb_wide  = {4'b0000, size_mask(i_size)} << i_off;
    assign w_wdata_wide = {32'h0000_0000, i_wdata} << w_shift;
    assign w_raw        = 32'({i_hi, i_lo} >> w_shift);

    assign o_strb0  = w_strb_wide[3:0];
    assign o_strb1  = w_strb_wide[7:4];
    assign o_wdata0 = w_wdata_wide[31:0];
    assign o_wdata1 = w_wdata_wide[63:32];

    always_comb begin
        o_rdata = w_raw;
        case (i_size)
            SZ_BYTE: o_rdata = i_unsigned ? {24'h000000, w_raw[7:0]}
                                          : {{24{w_raw[7]}}, w_raw[7:0]};
            SZ_HALF: o_rdata = i_unsigned ? {16'h0000, w_raw[15:0]}
                                          : {{16{w_raw[15]}}, w_raw[15:0]};
            default: o_rdata = w_raw;
        endcase
    end

endmodule

// File: rtl/misaligned_access_ctrl.sv
// Sequences one pipeline load/store onto the word bus, splitting word-crossing accesses.
//   state | meaning
//   IDLE  | waiting for req_valid_i, request fields captured on entry to BEAT0
//   BEAT0 | bus beat at the word holding the first byte
//   BEAT1 | bus beat at the following word (crossing accesses only)
//   RESP  | done_o pulse, result (or rejection) presented, pipeline released
module misaligned_access_ctrl
    import lsu_pkg::*;
#(
    parameter bit SUPPORT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    misaligned_access_ctrl_if.master bus
);

    lsu_state_t   r_state;
    lsu_state_t   w_next;
    logic [31:0]  r_addr;
    access_size_t r_size;
    logic         r_we;
    logic         r_uns;
    logic [31:0]  r_wdata;
    logic [31:0]  r_lo;
    logic [31:0]  r_hi;
    logic         r_err;

    logic         w_req_split;
    logic         w_split;
    logic [3:0]   w_strb0;
    logic [3:0]   w_strb1;
    logic [31:0]  w_wdata0;
    logic [31:0]  w_wdata1;
    logic [31:0]  w_rdata;

    assign w_req_split = needs_split(req_addr_i[1:0], decode_size(req_size_i));
    assign w_split     = needs_split(r_addr[1:0], r_size);

    lsu_align u_align (
        .i_off      (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .i_wdata    (r_wdata),
        .i_lo       (r_lo),
        .i_hi       (r_hi),
        .o_strb0    (w_strb0),
        .o_strb1    (w_strb1),
        .o_wdata0   (w_wdata0),
        .o_wdata1   (w_wdata1),
        .o_rdata    (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_size  <= SZ_BYTE;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_wdata <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req_valid_i) begin
                r_addr  <= req_addr_i;
                r_size  <= decode_size(req_size_i);
                r_we    <= req_we_i;
                r_uns   <= req_unsigned_i;
                r_wdata <= req_wdata_i;
                r_err   <= w_req_split && !SUPPORT_MISALIGNED;
            end
            if (r_state == BEAT0 && bus.mem_ack_i) begin
                r_lo <= bus.mem_rdata_i;
            end
            if (r_state == BEAT1 && bus.mem_ack_i) begin
                r_hi <= bus.mem_rdata_i;
            end
        end
    end

    always_comb begin
        w_next          = r_state;
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.mem_strb_o  = '0;
        done_o          = 1'b0;
        err_o           = 1'b0;
        rdata_o         = '0;
        // Outputs are forced quiet during reset so a beat in flight is dropped at once.
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        w_next = (w_req_split && !SUPPORT_MISALIGNED) ? RESP : BEAT0;
                    end
                end
                BEAT0: begin
                    bus.mem_req_o   = 1'b1;
                    bus.mem_we_o    = r_we;
                    bus.mem_addr_o  = {r_addr[31:2], 2'b00};
                    bus.mem_strb_o  = w_strb0;
                    bus.mem_wdata_o = w_wdata0;
                    if (bus.mem_ack_i) begin
                        w_next = w_split ? BEAT1 : RESP;
                    end
                end
                BEAT1: begin
                    bus.mem_req_o   = 1'b1;
                    bus.mem_we_o    = r_we;
                    bus.mem_addr_o  = {r_addr[31:2] + 30'd1, 2'b00};
                    bus.mem_strb_o  = w_strb1;
                    bus.mem_wdata_o = w_wdata1;
                    if (bus.mem_ack_i) begin
                        w_next = RESP;
                    end
                end
                RESP: begin
                    done_o  = 1'b1;
                    err_o   = r_err;
                    rdata_o = (r_we || r_err) ? 32'h0000_0000 : w_rdata;
                    w_next  = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    assign stall_o = req_valid_i && (r_state != RESP);

endmodule

// File: tb/tb_misaligned_access_ctrl.sv
// Randomized bench for misaligned_access_ctrl against a byte-level memory model.
module tb_misaligned_access_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_we, req_uns;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, err;
    logic [31:0] rdata;

    logic        req2_valid, req2_we, req2_uns;
    logic [1:0]  req2_size;
    logic [31:0] req2_addr, req2_wdata;
    logic        stall2, done2, err2;
    logic [31:0] rdata2;

    misaligned_access_ctrl_if bus ();
    misaligned_access_ctrl_if bus2 ();

    misaligned_access_ctrl #(.SUPPORT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_we_i(req_we), .req_size_i(req_size),
        .req_unsigned_i(req_uns), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .stall_o(stall), .done_o(done), .rdata_o(rdata), .err_o(err),
        .bus(bus.master)
    );

    misaligned_access_ctrl #(.SUPPORT_MISALIGNED(1'b0)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid_i(req2_valid), .req_we_i(req2_we), .req_size_i(req2_size),
        .req_unsigned_i(req2_uns), .req_addr_i(req2_addr), .req_wdata_i(req2_wdata),
        .stall_o(stall2), .done_o(done2), .rdata_o(rdata2), .err_o(err2),
        .bus(bus2.master)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        we;
    } beat_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          cycles;
        logic        stable;
    } blog_t;

    beat_t exp_beats[$];
    resp_t exp_resp[$];
    blog_t beat_log[$];
    resp_t resp_log[$];

    bit [31:0] bus_mem[bit [31:0]];
    bit [7:0]  model_mem[bit [31:0]];

    int force_wait = -1;
    bit block_en = 1'b0;
    logic [31:0] block_addr = 32'h0;

    function automatic bit [31:0] dflt(bit [31:0] wa);
        return (wa * 32'h9E37_79B1) ^ 32'h5A3C_96E1;
    endfunction

    function automatic bit [31:0] bus_read(bit [31:0] wa);
        return bus_mem.exists(wa) ? bus_mem[wa] : dflt(wa);
    endfunction

    function automatic bit [7:0] model_byte(bit [31:0] a);
        bit [31:0] w;
        if (model_mem.exists(a)) return model_mem[a];
        w = dflt({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    function automatic logic [31:0] lane_mask(logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    task automatic preload(input bit [31:0] a, input bit [31:0] d);
        bus_mem[a] = d;
        for (int i = 0; i < 4; i++) model_mem[a + i] = d[8*i +: 8];
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected beats and result, derived byte by byte from the little-endian address map.
    task automatic model_push(input logic [31:0] a, input logic [1:0] sz, input logic we,
                              input logic uns, input logic [31:0] wd);
        int n, nb, k;
        logic [31:0] b0, ba, val;
        beat_t bt[2];
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        b0 = {a[31:2], 2'b00};
        bt[0] = '{b0, 4'h0, 32'h0, we};
        bt[1] = '{b0 + 32'd4, 4'h0, 32'h0, we};
        nb  = 1;
        val = 32'h0;
        for (int i = 0; i < n; i++) begin
            ba = a + i;
            k  = ({ba[31:2], 2'b00} == b0) ? 0 : 1;
            if (k == 1) nb = 2;
            bt[k].strb[ba[1:0]] = 1'b1;
            bt[k].wdata[8*ba[1:0] +: 8] = wd[8*i +: 8];
            if (we) model_mem[ba] = wd[8*i +: 8];
            else    val[8*i +: 8] = model_byte(ba);
        end
        if (!we && !uns && n < 4 && val[8*n-1]) val = val | ~((32'h1 << (8*n)) - 32'h1);
        for (int i = 0; i < nb; i++) exp_beats.push_back(bt[i]);
        exp_resp.push_back('{we ? 32'h0 : val, 1'b0});
    endtask

    // Memory slave: random or forced wait states, applies writes by strobe.
    initial begin
        int waitc;
        bit [31:0] w;
        waitc = -1;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            bus.mem_ack_i   = 1'b0;
            bus.mem_rdata_i = $urandom;
            if (rst || !bus.mem_req_o) begin
                waitc = -1;
            end else if (!(block_en && bus.mem_addr_o == block_addr)) begin
                if (waitc < 0) waitc = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
                if (waitc == 0) begin
                    bus.mem_ack_i   = 1'b1;
                    bus.mem_rdata_i = bus_read(bus.mem_addr_o);
                    if (bus.mem_we_o) begin
                        w = bus_read(bus.mem_addr_o);
                        for (int l = 0; l < 4; l++)
                            if (bus.mem_strb_o[l]) w[8*l +: 8] = bus.mem_wdata_o[8*l +: 8];
                        bus_mem[bus.mem_addr_o] = w;
                    end
                    waitc = -1;
                end else begin
                    waitc--;
                end
            end
        end
    end

    // Compare process: every bus cycle and every completion against the model queues.
    initial begin
        bit    in_beat;
        blog_t cur;
        beat_t e;
        resp_t r;
        in_beat = 1'b0;
        cur = '{32'h0, 4'h0, 32'h0, 0, 1'b1};
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                exp_beats.delete();
                exp_resp.delete();
                in_beat = 1'b0;
            end else begin
                if (bus.mem_req_o) begin
                    checks++;
                    if (exp_beats.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got addr %h expected no request", bus.mem_addr_o);
                    end else begin
                        e = exp_beats[0];
                        if (bus.mem_addr_o !== e.addr || bus.mem_strb_o !== e.strb ||
                            bus.mem_we_o !== e.we ||
                            (e.we && ((bus.mem_wdata_o ^ e.wdata) & lane_mask(e.strb)) != 32'h0)) begin
                            errors++;
                            $display("FAIL beat: got addr %h strb %b we %b wdata %h expected addr %h strb %b we %b wdata %h",
                                     bus.mem_addr_o, bus.mem_strb_o, bus.mem_we_o, bus.mem_wdata_o,
                                     e.addr, e.strb, e.we, e.wdata);
                        end
                        if (!in_beat) begin
                            cur = '{bus.mem_addr_o, bus.mem_strb_o, bus.mem_wdata_o, 1, 1'b1};
                            in_beat = 1'b1;
                        end else begin
                            cur.cycles++;
                            if (bus.mem_addr_o !== cur.addr || bus.mem_strb_o !== cur.strb ||
                                bus.mem_wdata_o !== cur.wdata) cur.stable = 1'b0;
                        end
                        if (bus.mem_ack_i) begin
                            beat_log.push_back(cur);
                            void'(exp_beats.pop_front());
                            in_beat = 1'b0;
                        end
                    end
                end
                if (done) begin
                    checks++;
                    if (exp_resp.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done: got rdata %h expected no completion", rdata);
                    end else begin
                        r = exp_resp.pop_front();
                        if (rdata !== r.rdata || err !== r.err || exp_beats.size() != 0) begin
                            errors++;
                            $display("FAIL resp: got rdata %h err %b pending beats %0d expected rdata %h err %b pending beats 0",
                                     rdata, err, exp_beats.size(), r.rdata, r.err);
                        end
                    end
                    resp_log.push_back('{rdata, err});
                end else if (err) begin
                    checks++;
                    errors++;
                    $display("FAIL err_without_done: got err 1 expected 0");
                end
            end
        end
    end

    task automatic run_req(input logic [31:0] a, input logic [1:0] sz, input logic we,
                           input logic uns, input logic [31:0] wd,
                           output int done_cyc, output int stall_cnt);
        @(negedge clk);
        model_push(a, sz, we, uns, wd);
        req_valid = 1'b1;
        req_addr  = a;
        req_size  = sz;
        req_we    = we;
        req_uns   = uns;
        req_wdata = wd;
        done_cyc  = 0;
        stall_cnt = 0;
        for (int c = 1; c <= 60; c++) begin
            #3;
            if (stall) stall_cnt++;
            if (done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
        if (done_cyc == 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no done_o within 60 cycles expected done_o");
        end
        req_valid = 1'b0;
        req_wdata = $urandom;
    endtask

    initial begin
        int dc, sc, cnt, seen;
        logic [31:0] a;
        #500000;
        $display("FAIL watchdog: got no end of test expected $finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, sc, cnt, seen;
        logic [31:0] a;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_uns = 1'b0; req_size = 2'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        req2_valid = 1'b0; req2_we = 1'b0; req2_uns = 1'b0; req2_size = 2'd0;
        req2_addr = 32'h0; req2_wdata = 32'h0;
        bus2.mem_ack_i   = 1'b1;
        bus2.mem_rdata_i = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #3;
        chk("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we_o), 32'h0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
        chk("rst_mem_strb", 32'(bus.mem_strb_o), 32'h0);
        chk("rst_done_err", {30'h0, done, err}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);

        force_wait = 0;
        preload(32'h100, 32'hDEAD_BEEF);
        beat_log.delete(); resp_log.delete();
        run_req(32'h100, 2'd2, 1'b0, 1'b0, 32'h0, dc, sc);
        chk("lw_al_addr", beat_log[0].addr, 32'h100);
        chk("lw_al_strb", 32'(beat_log[0].strb), 32'hF);
        chk("lw_al_done_cycle", dc, 3);
        chk("lw_al_stall_cycles", sc, 2);
        chk("lw_al_rdata", resp_log[0].rdata, 32'hDEAD_BEEF);

        preload(32'h100, 32'h1122_3344);
        preload(32'h104, 32'h5566_7788);
        beat_log.delete(); resp_log.delete();
        run_req(32'h102, 2'd2, 1'b0, 1'b0, 32'h0, dc, sc);
        chk("lw_mis_addr0", beat_log[0].addr, 32'h100);
        chk("lw_mis_strb0", 32'(beat_log[0].strb), 32'hC);
        chk("lw_mis_addr1", beat_log[1].addr, 32'h104);
        chk("lw_mis_strb1", 32'(beat_log[1].strb), 32'h3);
        chk("lw_mis_rdata", resp_log[0].rdata, 32'h7788_1122);
        chk("lw_mis_done_cycle", dc, 4);

        beat_log.delete(); resp_log.delete();
        run_req(32'h103, 2'd2, 1'b1, 1'b0, 32'hAABB_CCDD, dc, sc);
        chk("sw_addr0", beat_log[0].addr, 32'h100);
        chk("sw_strb0", 32'(beat_log[0].strb), 32'h8);
        chk("sw_wdata0", beat_log[0].wdata, 32'hDD00_0000);
        chk("sw_addr1", beat_log[1].addr, 32'h104);
        chk("sw_strb1", 32'(beat_log[1].strb), 32'h7);
        chk("sw_wdata1", beat_log[1].wdata, 32'h00AA_BBCC);
        chk("sw_rdata", resp_log[0].rdata, 32'h0);

        preload(32'h100, 32'h8000_0000);
        preload(32'h104, 32'h0000_00FF);
        resp_log.delete();
        run_req(32'h103, 2'd1, 1'b0, 1'b0, 32'h0, dc, sc);
        run_req(32'h103, 2'd1, 1'b0, 1'b1, 32'h0, dc, sc);
        chk("lh_rdata", resp_log[0].rdata, 32'hFFFF_FF80);
        chk("lhu_rdata", resp_log[1].rdata, 32'h0000_FF80);

        preload(32'h000, 32'h0000_F000);
        beat_log.delete(); resp_log.delete();
        run_req(32'h001, 2'd0, 1'b0, 1'b0, 32'h0, dc, sc);
        chk("lb_rdata", resp_log[0].rdata, 32'hFFFF_FFF0);
        chk("lb_beats", beat_log.size(), 1);

        beat_log.delete();
        run_req(32'hFFFF_FFFE, 2'd2, 1'b0, 1'b0, 32'h0, dc, sc);
        chk("wrap_addr0", beat_log[0].addr, 32'hFFFF_FFFC);
        chk("wrap_addr1", beat_log[1].addr, 32'h0000_0000);

        force_wait = 3;
        beat_log.delete();
        run_req(32'h108, 2'd2, 1'b0, 1'b0, 32'h0, dc, sc);
        chk("wait_beat_cycles", beat_log[0].cycles, 4);
        chk("wait_beat_stable", 32'(beat_log[0].stable), 32'h1);
        chk("wait_done_cycle", dc, 6);

        // Reset while the second beat is held off by the slave.
        force_wait = 0;
        block_en   = 1'b1;
        block_addr = 32'h104;
        @(negedge clk);
        model_push(32'h102, 2'd2, 1'b0, 1'b0, 32'h0);
        req_valid = 1'b1; req_addr = 32'h102; req_size = 2'd2; req_we = 1'b0; req_uns = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            #3;
            if (bus.mem_req_o && bus.mem_addr_o == 32'h104) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_reached_beat1", seen, 1);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        block_en = 1'b0;
        #3;
        chk("rst_mid_req_dropped", 32'(bus.mem_req_o), 32'h0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (done || bus.mem_req_o) cnt++;
            @(negedge clk);
            #3;
        end
        chk("rst_mid_no_done", cnt, 0);

        force_wait = -1;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF8 + $urandom_range(0, 7);
            else                           a = 32'h100 + $urandom_range(0, 63);
            run_req(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom, dc, sc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        req2_valid = 1'b1; req2_addr = 32'h101; req2_size = 2'd2; req2_we = 1'b0;
        cnt = 0; seen = 0;
        for (int c = 0; c < 6; c++) begin
            #3;
            if (err2) cnt++;
            if (bus2.mem_req_o) seen++;
            if (done2) req2_valid = 1'b0;
            @(negedge clk);
        end
        req2_valid = 1'b0;
        chk("nomis_err_pulses", cnt, 1);
        chk("nomis_no_bus_req", seen, 0);

        @(negedge clk);
        req2_valid = 1'b1; req2_addr = 32'h100; req2_size = 2'd2;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            #3;
            if (done2) begin
                chk("nomis_aligned_rdata", rdata2, 32'hCAFE_F00D);
                chk("nomis_aligned_err", 32'(err2), 32'h0);
                seen = 1;
                req2_valid = 1'b0;
                break;
            end
            @(negedge clk);
        end
        req2_valid = 1'b0;
        chk("nomis_aligned_done", seen, 1);

        repeat (3) @(negedge clk);
        chk("queues_drained", exp_beats.size() + exp_resp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
